// File: rtl/pmt_buffer_stage.sv
// pmt_buffer_stage: ping-pong per-lane frame buffer read back in stride-4 transposed order.
module pmt_buffer_stage #(
  parameter int DATA_WIDTH   = 16,
  parameter int PROBLEM_SIZE = 64,
  parameter int ADDR_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_in,
  input  logic [DATA_WIDTH-1:0] x_a_in,
  input  logic [DATA_WIDTH-1:0] y_a_in,
  input  logic [DATA_WIDTH-1:0] x_b_in,
  input  logic [DATA_WIDTH-1:0] y_b_in,
  input  logic [DATA_WIDTH-1:0] x_c_in,
  input  logic [DATA_WIDTH-1:0] y_c_in,
  input  logic [DATA_WIDTH-1:0] x_d_in,
  input  logic [DATA_WIDTH-1:0] y_d_in,
  output logic [DATA_WIDTH-1:0] x_a_out,
  output logic [DATA_WIDTH-1:0] y_a_out,
  output logic [DATA_WIDTH-1:0] x_b_out,
  output logic [DATA_WIDTH-1:0] y_b_out,
  output logic [DATA_WIDTH-1:0] x_c_out,
  output logic [DATA_WIDTH-1:0] y_c_out,
  output logic [DATA_WIDTH-1:0] x_d_out,
  output logic [DATA_WIDTH-1:0] y_d_out,
  output logic                  ctrl_out
);
  localparam int D = PROBLEM_SIZE / 4;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(D - 1);
  typedef enum logic {W_IDLE, W_FILL} w_state_t;
  typedef enum logic {R_IDLE, R_READ} r_state_t;
  w_state_t r_wst, w_wst_nxt;
  r_state_t r_rst_q, w_rst_nxt;
  logic [ADDR_WIDTH-1:0] r_wc, w_wc_nxt, r_rc, w_rc_nxt, w_wlo, w_rot;
  logic r_wr_bank, w_wr_bank_nxt, r_rd_bank, w_rd_bank_nxt;
  logic w_we, w_frame_done, w_rd_act, r_ctrl;
  logic [ADDR_WIDTH:0] w_waddr, w_raddr;
  logic [DATA_WIDTH-1:0] w_din [8];
  logic [DATA_WIDTH-1:0] w_dout [8];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wst     <= W_IDLE;
      r_rst_q   <= R_IDLE;
      r_wc      <= '0;
      r_rc      <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      r_wst     <= w_wst_nxt;
      r_rst_q   <= w_rst_nxt;
      r_wc      <= w_wc_nxt;
      r_rc      <= w_rc_nxt;
      r_wr_bank <= w_wr_bank_nxt;
      r_rd_bank <= w_rd_bank_nxt;
    end
  end
  // a ctrl_in pulse always restarts the frame, discarding any partial one
  always_comb begin
    w_wst_nxt     = r_wst;
    w_wc_nxt      = r_wc;
    w_wr_bank_nxt = r_wr_bank;
    w_we          = 1'b0;
    w_wlo         = r_wc;
    w_frame_done  = 1'b0;
    if (ctrl_in) begin
      w_we      = 1'b1;
      w_wlo     = '0;
      w_wc_nxt  = ADDR_WIDTH'(1);
      w_wst_nxt = W_FILL;
    end else if (r_wst == W_FILL) begin
      w_we     = 1'b1;
      w_wc_nxt = r_wc + 1'b1;
      if (r_wc == LAST) begin
        w_frame_done  = 1'b1;
        w_wr_bank_nxt = ~r_wr_bank;
        w_wst_nxt     = W_IDLE;
      end
    end
    w_rst_nxt     = r_rst_q;
    w_rc_nxt      = r_rc;
    w_rd_bank_nxt = r_rd_bank;
    if (w_frame_done) begin
      w_rst_nxt     = R_READ;
      w_rc_nxt      = '0;
      w_rd_bank_nxt = r_wr_bank;
    end else if (r_rst_q == R_READ) begin
      w_rc_nxt  = r_rc + 1'b1;
      w_rst_nxt = (r_rc == LAST) ? R_IDLE : R_READ;
    end
  end
  if (ADDR_WIDTH == 2) begin : g_rot_id
    assign w_rot = r_rc;
  end else begin : g_rot
    assign w_rot = {r_rc[ADDR_WIDTH-3:0], r_rc[ADDR_WIDTH-1:ADDR_WIDTH-2]};
  end
  assign w_waddr  = {r_wr_bank, w_wlo};
  assign w_raddr  = {r_rd_bank, w_rot};
  assign w_rd_act = (r_rst_q == R_READ);
  assign w_din    = '{x_a_in, y_a_in, x_b_in, y_b_in, x_c_in, y_c_in, x_d_in, y_d_in};
  for (genvar g = 0; g < 8; g++) begin : g_lane
    logic [DATA_WIDTH-1:0] r_mem [2*D];
    logic [DATA_WIDTH-1:0] r_q;
    always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= w_din[g];
      r_q <= (rst || !w_rd_act) ? '0 : r_mem[w_raddr];
    end
    assign w_dout[g] = r_q;
  end
  always_ff @(posedge clk) r_ctrl <= !rst && w_rd_act && (r_rc == '0);
  assign {x_a_out, y_a_out, x_b_out, y_b_out} = {w_dout[0], w_dout[1], w_dout[2], w_dout[3]};
  assign {x_c_out, y_c_out, x_d_out, y_d_out} = {w_dout[4], w_dout[5], w_dout[6], w_dout[7]};
  assign ctrl_out = r_ctrl;
endmodule

// File: tb/tb_pmt_buffer_stage.sv
// tb_pmt_buffer_stage: directed frame schedules with hand-derived output timing and order.
module tb_pmt_buffer_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ctrl_in = 1'b0;
  logic c2_in = 1'b0;
  logic [15:0] d [8];
  logic [15:0] q [8];
  logic [15:0] q2 [8];
  logic ctrl_out, ctrl2_out;
  int n_vec = 0, n_err = 0;
  int in_st [4], in_base [4], out_st [4], out_base [4];
  int n_in, n_out, rst_at;
  always #5 clk = ~clk;
  pmt_buffer_stage dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in),
    .x_a_in(d[0]), .y_a_in(d[1]), .x_b_in(d[2]), .y_b_in(d[3]),
    .x_c_in(d[4]), .y_c_in(d[5]), .x_d_in(d[6]), .y_d_in(d[7]),
    .x_a_out(q[0]), .y_a_out(q[1]), .x_b_out(q[2]), .y_b_out(q[3]),
    .x_c_out(q[4]), .y_c_out(q[5]), .x_d_out(q[6]), .y_d_out(q[7]),
    .ctrl_out(ctrl_out)
  );
  pmt_buffer_stage #(.DATA_WIDTH(16), .PROBLEM_SIZE(16), .ADDR_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .ctrl_in(c2_in),
    .x_a_in(d[0]), .y_a_in(d[1]), .x_b_in(d[2]), .y_b_in(d[3]),
    .x_c_in(d[4]), .y_c_in(d[5]), .x_d_in(d[6]), .y_d_in(d[7]),
    .x_a_out(q2[0]), .y_a_out(q2[1]), .x_b_out(q2[2]), .y_b_out(q2[3]),
    .x_c_out(q2[4]), .y_c_out(q2[5]), .x_d_out(q2[6]), .y_d_out(q2[7]),
    .ctrl_out(ctrl2_out)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] ev(input int base, input int k, input int w);
    return 16'(base + (k / 2) * 'h1000 + (k % 2) * 'h100 + w);
  endfunction
  function automatic int rot16(input int k);
    return (k % 4) * 4 + k / 4;
  endfunction
  task automatic drive_word(input logic c, input int base, input int w);
    ctrl_in = c;
    for (int k = 0; k < 8; k++) d[k] = ev(base, k, w);
  endtask
  task automatic drive_idle();
    ctrl_in = 1'b0;
    for (int k = 0; k < 8; k++) d[k] = 16'hE000 | 16'(k);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic run(input string name, input int n_cyc);
    for (int c = 0; c < n_cyc; c++) begin
      int s, ob;
      bit ex_act, ex_ctrl;
      int kk;
      s = -1;
      for (int i = 0; i < n_in; i++) if (in_st[i] <= c) s = i;
      if (s >= 0 && c - in_st[s] < 16) drive_word(c == in_st[s], in_base[s], c - in_st[s]);
      else drive_idle();
      rst = (c == rst_at);
      ex_act = 1'b0; ex_ctrl = 1'b0; ob = 0; kk = 0;
      for (int i = 0; i < n_out; i++)
        if (c >= out_st[i] && c - out_st[i] < 16 && !(rst_at >= 0 && c > rst_at)) begin
          ex_act = 1'b1; ex_ctrl = (c == out_st[i]); ob = out_base[i]; kk = c - out_st[i];
        end
      @(negedge clk);
      chk($sformatf("%s c%0d ctrl_out", name, c), 32'(ctrl_out), 32'(ex_ctrl));
      for (int k = 0; k < 8; k++)
        chk($sformatf("%s c%0d lane%0d", name, c, k), 32'(q[k]),
            ex_act ? 32'(ev(ob, k, rot16(kk))) : 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask
  initial begin
    drive_idle();
    do_reset();
    @(negedge clk);
    chk("reset ctrl_out", 32'(ctrl_out), 32'd0);
    chk("reset x_a_out", 32'(q[0]), 32'd0);
    chk("reset y_d_out", 32'(q[7]), 32'd0);
    chk("reset ctrl2_out", 32'(ctrl2_out), 32'd0);
    @(posedge clk);
    #1;
    rst_at = -1;
    n_in = 1; in_st[0] = 0; in_base[0] = 'h100;
    n_out = 1; out_st[0] = 17; out_base[0] = 'h100;
    run("single", 40);
    do_reset();
    n_in = 2; in_st[1] = 16; in_base[1] = 'h180;
    n_out = 2; out_st[1] = 33; out_base[1] = 'h180;
    run("b2b", 55);
    do_reset();
    n_in = 2; in_st[1] = 7; in_base[1] = 'h300;
    n_out = 1; out_st[0] = 24; out_base[0] = 'h300;
    run("restart", 45);
    do_reset();
    rst_at = 20;
    n_in = 1; n_out = 1; out_st[0] = 17; out_base[0] = 'h100;
    run("midrst", 60);
    rst_at = -1;
    do_reset();
    n_in = 3; in_st[1] = 20; in_base[1] = 'h140; in_st[2] = 40; in_base[2] = 'h180;
    n_out = 3; out_st[1] = 37; out_base[1] = 'h140; out_st[2] = 57; out_base[2] = 'h180;
    run("spaced", 80);
    do_reset();
    for (int c = 0; c < 12; c++) begin
      c2_in = (c == 0);
      if (c < 4) for (int k = 0; k < 8; k++) d[k] = ev('h100, k, c);
      else for (int k = 0; k < 8; k++) d[k] = 16'hE000;
      @(negedge clk);
      chk($sformatf("n16 c%0d ctrl_out", c), 32'(ctrl2_out), 32'(c == 5));
      chk($sformatf("n16 c%0d x_a", c), 32'(q2[0]), (c >= 5 && c < 9) ? 32'(ev('h100, 0, c - 5)) : 32'd0);
      chk($sformatf("n16 c%0d y_d", c), 32'(q2[7]), (c >= 5 && c < 9) ? 32'(ev('h100, 7, c - 5)) : 32'd0);
      @(posedge clk);
      #1;
    end
    c2_in = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
